// File: rtl/ternary_pkg.sv
// rtl/ternary_pkg.sv - shared FSM type, widths and digit-sum helper for the ternary sampler
package ternary_pkg;

  localparam int COEF_W = 2;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Base-4 digit sum keeps the byte's residue mod 3 because 4 = 1 (mod 3).
  function automatic logic [3:0] digit_sum4(input logic [BYTE_W-1:0] b);
    return {2'b00, b[1:0]} + {2'b00, b[3:2]} + {2'b00, b[5:4]} + {2'b00, b[7:6]};
  endfunction

endpackage

// File: rtl/mod3_lane_u8.sv
// rtl/mod3_lane_u8.sv - one lane: byte digit-sum (stage 1) then mod-3 coefficient (stage 2)
// Option TERNARY_SIGNED_EN: residue 2 is emitted as 2'b11 instead of 2'b10.
module mod3_lane_u8
  import ternary_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld1,
  input  logic              ld2,
  input  logic              kill,
  input  logic [BYTE_W-1:0] data,
  output logic [COEF_W-1:0] coef
);

  logic [3:0]        dsum;
  logic [COEF_W-1:0] res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsum <= '0;
    end else if (ld1) begin
      dsum <= kill ? 4'd0 : digit_sum4(data);
    end
  end

  // dsum never exceeds 12, so codes 13..15 fall to the default.
  always_comb begin
    res = '0;
    case (dsum)
      4'd1, 4'd4, 4'd7, 4'd10: res = 2'b01;
`ifdef TERNARY_SIGNED_EN
      4'd2, 4'd5, 4'd8, 4'd11: res = 2'b11;
`else
      4'd2, 4'd5, 4'd8, 4'd11: res = 2'b10;
`endif
      default:                 res = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef <= '0;
    end else if (ld2) begin
      coef <= res;
    end
  end

endmodule

// File: rtl/ternary_sampler_stream.sv
// rtl/ternary_sampler_stream.sv - streaming LANES-wide mod-3 ternary sampler, N_COEF coefficients per run
// Option TERNARY_SIGNED_EN (in mod3_lane_u8): signed 00/01/11 coefficient encoding.
module ternary_sampler_stream
  import ternary_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int N_COEF = 700
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BYTE_W*LANES-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COEF_W*LANES-1:0]   out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int CNT_W = $clog2(N_COEF + 1);
  localparam int BEATS = (N_COEF + LANES - 1) / LANES;
  localparam int REM   = N_COEF - (BEATS - 1) * LANES;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             s1_valid, s1_last, s2_valid, s2_last;
  logic             en, accept, last_beat;

  assign en        = !s2_valid || out_ready;
  assign in_ready  = (state == RUN) && en;
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign out_valid = s2_valid;
  assign out_last  = s2_valid && s2_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN:   if (accept && last_beat) state_nx = DRAIN;
      DRAIN: if (out_valid && out_ready && out_last) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Valid/last travel beside the lane datapath and stall with it as one unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      s1_last  <= accept && last_beat;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mod3_lane_u8 u_lane (
      .clk  (clk),
      .rst  (rst),
      .ld1  (accept),
      .ld2  (en && s1_valid),
      .kill (last_beat && (k >= REM)),
      .data (in_data[BYTE_W*k +: BYTE_W]),
      .coef (out_data[COEF_W*k +: COEF_W])
    );
  end

endmodule

// File: tb/tb_ternary_sampler_stream.sv
// tb/tb_ternary_sampler_stream.sv - scoreboard bench: 700-coefficient random runs plus a 6-coefficient directed instance
module tb_ternary_sampler_stream;

  localparam int LANES   = 4;
  localparam int N_A     = 700;
  localparam int N_B     = 6;
  localparam int BEATS_A = (N_A + LANES - 1) / LANES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               a_start = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic               a_in_ready, a_out_valid, a_out_last, a_busy, a_done;
  logic [8*LANES-1:0] a_in_data = '0;
  logic [2*LANES-1:0] a_out_data;

  logic               b_start = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic               b_in_ready, b_out_valid, b_out_last, b_busy, b_done;
  logic [8*LANES-1:0] b_in_data = '0;
  logic [2*LANES-1:0] b_out_data;

  ternary_sampler_stream #(.LANES(LANES), .N_COEF(N_A)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy), .done(a_done)
  );

  ternary_sampler_stream #(.LANES(LANES), .N_COEF(N_B)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy), .done(b_done)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int         qb_t[$];
  int         a_pops = 0, a_dones = 0, b_pops = 0, b_dones = 0;
  bit         a_hold = 0, a_done_exp = 0, b_done_exp = 0;
  logic [9:0] a_prev;
  logic [8:0] a_e, b_e;
  int         b_t;

  always @(negedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [1:0] coef_of(input logic [7:0] b);
    int r;
    r = int'(b) % 3;
`ifdef TERNARY_SIGNED_EN
    return (r == 2) ? 2'b11 : 2'(r);
`else
    return 2'(r);
`endif
  endfunction

  // Coefficient index beat*LANES+k exists only below n_coef; missing ones read as zero.
  function automatic logic [8:0] expect_beat(input logic [31:0] bytes, input int beat, input int n_coef);
    logic [7:0] d;
    int beats;
    beats = (n_coef + LANES - 1) / LANES;
    d = '0;
    for (int k = 0; k < LANES; k++)
      if (beat * LANES + k < n_coef) d[2*k +: 2] = coef_of(bytes[8*k +: 8]);
    return {beat == beats - 1, d};
  endfunction

  always @(negedge clk) begin
    #2;
    if (rst) begin
      a_hold = 0;
      a_done_exp = 0;
    end else begin
      check("a_done_timing", 32'(a_done), 32'(a_done_exp));
      if (a_done) begin
        a_dones++;
        check("a_busy_at_done", 32'(a_busy), 32'd0);
      end
      a_done_exp = 0;
      if (a_hold) check("a_stall_hold", 32'({a_out_valid, a_out_last, a_out_data}), 32'({1'b1, a_prev[8:0]}));
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          check("a_unexpected_beat", 32'(a_out_valid), 32'd0);
        end else begin
          a_e = qa.pop_front();
          check("a_beat", 32'({a_out_last, a_out_data}), 32'(a_e));
          a_pops++;
          if (a_e[8]) a_done_exp = 1;
        end
      end
      a_hold = a_out_valid && !a_out_ready;
      a_prev = {1'b0, a_out_last, a_out_data};
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst) begin
      b_done_exp = 0;
    end else begin
      check("b_done_timing", 32'(b_done), 32'(b_done_exp));
      if (b_done) b_dones++;
      b_done_exp = 0;
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          check("b_unexpected_beat", 32'(b_out_valid), 32'd0);
        end else begin
          b_e = qb.pop_front();
          b_t = qb_t.pop_front();
          check("b_beat", 32'({b_out_last, b_out_data}), 32'(b_e));
          check("b_latency", 32'(cyc), 32'(b_t + 2));
          b_pops++;
          if (b_e[8]) b_done_exp = 1;
        end
      end
    end
  end

  task automatic run_b(input logic [31:0] d, input logic [8:0] e0, input logic [8:0] e1);
    int base_dones = b_dones;
    int base_pops  = b_pops;
    int beat  = 0;
    int guard = 0;
    b_out_ready = 1'b1;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    while (beat < 2 && guard < 50) begin
      b_in_valid = 1'b1;
      b_in_data  = d;
      #1;
      if (b_in_ready) begin
        qb.push_back(beat == 0 ? e0 : e1);
        qb_t.push_back(cyc);
        beat++;
      end
      @(negedge clk);
      guard++;
    end
    b_in_valid = 1'b0;
    guard = 0;
    while (b_dones == base_dones && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("b_beat_count", 32'(b_pops - base_pops), 32'd2);
    check("b_done_count", 32'(b_dones - base_dones), 32'd1);
    check("b_queue_empty", 32'(qb.size()), 32'd0);
  endtask

  task automatic run_a(input int abort_after, input bit toggle_ready, input bit poke);
    int base_dones = a_dones;
    int base_pops  = a_pops;
    int beat  = 0;
    int guard = 0;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    while (beat < BEATS_A && beat != abort_after && guard < 4000) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_data   = $urandom;
      a_out_ready = toggle_ready ? ~guard[0] : 1'($urandom_range(0, 1));
      a_start     = poke && a_busy && ($urandom_range(0, 5) == 0);
      #1;
      if (a_in_valid && a_in_ready) begin
        qa.push_back(expect_beat(a_in_data, beat, N_A));
        beat++;
      end
      @(negedge clk);
      guard++;
    end
    a_in_valid = 1'b0;
    a_start    = 1'b0;
    if (beat == abort_after) begin
      #3 rst = 1'b1;
      #1;
      check("abort_out_valid", 32'(a_out_valid), 32'd0);
      check("abort_out_data", 32'(a_out_data), 32'd0);
      check("abort_flags", 32'({a_in_ready, a_out_last, a_busy, a_done}), 32'd0);
      qa.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      a_in_valid = 1'b1;
      repeat (3) begin
        @(negedge clk);
        #1;
        check("abort_idle_in_ready", 32'(a_in_ready), 32'd0);
        check("abort_idle_busy", 32'(a_busy), 32'd0);
      end
      a_in_valid = 1'b0;
      check("abort_no_done", 32'(a_dones - base_dones), 32'd0);
    end else begin
      guard = 0;
      while (a_dones == base_dones && guard < 4000) begin
        a_out_ready = toggle_ready ? ~guard[0] : 1'($urandom_range(0, 1));
        a_start     = poke && a_busy && ($urandom_range(0, 2) == 0);
        @(negedge clk);
        guard++;
      end
      a_start     = 1'b0;
      a_out_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("a_beat_count", 32'(a_pops - base_pops), 32'(BEATS_A));
      check("a_done_count", 32'(a_dones - base_dones), 32'd1);
      check("a_queue_empty", 32'(qa.size()), 32'd0);
      check("a_idle_busy", 32'(a_busy), 32'd0);
    end
  endtask

  initial begin
    #12;
    check("reset_a_out", 32'({a_out_valid, a_out_last, a_out_data}), 32'd0);
    check("reset_a_flags", 32'({a_in_ready, a_busy, a_done}), 32'd0);
    check("reset_b_out", 32'({b_out_valid, b_out_last, b_out_data}), 32'd0);
    check("reset_b_flags", 32'({b_in_ready, b_busy, b_done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef TERNARY_SIGNED_EN
    run_b(32'hFF_FE_02_01, {1'b0, 8'b00_11_11_01}, {1'b1, 8'b00_00_11_01});
    run_b(32'h05050505,    {1'b0, 8'hFF},          {1'b1, 8'h0F});
`else
    run_b(32'hFF_FE_02_01, {1'b0, 8'b00_10_10_01}, {1'b1, 8'b00_00_10_01});
    run_b(32'h05050505,    {1'b0, 8'hAA},          {1'b1, 8'h0A});
`endif

    run_a(-1, 1'b1, 1'b0);
    run_a(50, 1'b0, 1'b0);
    run_a(-1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
